cache_arbiter: RTL

- Shares the single physical-memory line port (cacheline adaptor side) between the instruction cache and the data cache of the pipelined CPU.
- Accepts line-granular read/write requests from both caches and grants one at a time.
- Latches the winner's command and forwards it downstream, then routes the response back to the winner only.
- Sits between the I-cache/D-cache pmem ports and the cacheline adaptor.

---
 rtl/cache_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto one downstream memory port.
// Optional `CACHE_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of D-over-I priority.
module cache_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  d_req;
    logic                  grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        d_req        = d_pmem_read | d_pmem_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        // On contention the side that did not win last time goes first.
        grant_d      = d_req & (~i_pmem_read | ~last_grant_q);
`else
        grant_d      = d_req;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = 1'b1;
                    op_write_d   = d_pmem_write;
                    addr_d       = d_pmem_address;
                    wdata_d      = d_pmem_wdata;
                end else if (i_pmem_read) begin
                    state_d      = SERVE_I;
                    last_grant_d = 1'b0;
                    op_write_d   = 1'b0;
                    addr_d       = i_pmem_address;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_read     = (state_q != IDLE) & ~op_write_q;
    assign mem_write    = (state_q != IDLE) &  op_write_q;
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;
    assign i_pmem_resp  = (state_q == SERVE_I) & mem_resp;
    assign d_pmem_resp  = (state_q == SERVE_D) & mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

`ifndef SYNTHESIS
    // Simultaneous read and write from the D-cache is a requester bug; write still wins.
    always_ff @(posedge clk) begin
        if (rst && state_q == IDLE) begin
            assert (!(d_pmem_read && d_pmem_write));
        end
    end
`endif

endmodule
